// File: rtl/alu_cmd_pkg.sv
// rtl/alu_cmd_pkg.sv - function codes, command-word fields, FSM states, request type and pack_cmd
package alu_cmd_pkg;

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_MUL = 4'd2;
    localparam logic [3:0] FN_DIV = 4'd3;
    localparam logic [3:0] FN_AND = 4'd4;
    localparam logic [3:0] FN_OR  = 4'd5;
    localparam logic [3:0] FN_XOR = 4'd6;
    localparam logic [3:0] FN_NOT = 4'd7;
    localparam logic [3:0] FN_PA  = 4'd8;
    localparam logic [3:0] FN_PB  = 4'd9;
    localparam logic [3:0] FN_SLL = 4'd10;
    localparam logic [3:0] FN_SRL = 4'd11;
    localparam logic [3:0] FN_SRA = 4'd12;
    localparam logic [3:0] FN_INC = 4'd13;
    localparam logic [3:0] FN_DEC = 4'd14;
    localparam logic [3:0] FN_HAM = 4'd15;

    localparam int CMD_FUNC_MSB = 31;
    localparam int CMD_FUNC_LSB = 28;
    localparam int CMD_A_MSB    = 15;
    localparam int CMD_B_MSB    = 7;
    localparam int CMD_TAG_MSB  = 23;

    // ST_ISSUE is folded into the IDLE->WAIT edge; it keeps its encoding but is never entered.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } issuer_state_t;

    typedef struct packed {
        logic [3:0] func;
        logic [7:0] a;
        logic [7:0] b;
    } alu_req_t;

    function automatic logic [31:0] pack_cmd(input logic [3:0] func, input logic [7:0] a,
                                             input logic [7:0] b);
        logic [31:0] w_cmd;
        w_cmd = '0;
        w_cmd[CMD_FUNC_MSB:CMD_FUNC_LSB] = func;
        w_cmd[CMD_A_MSB -: 8]             = a;
        w_cmd[CMD_B_MSB -: 8]             = b;
        return w_cmd;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// rtl/alu_req_fifo.sv - DEPTH x 20-bit request FIFO; extra pointer bit separates full from empty
module alu_req_fifo
    import alu_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  alu_req_t i_data,
    input  logic     i_pop,
    output alu_req_t o_head,
    output logic     o_full,
    output logic     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    alu_req_t    r_mem [DEPTH];
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - buffers ALU requests, issues one command at a time, returns results
// Optional CMD_TAG_EN: issue counter drives cmd[23:16] and is returned on rsp_tag.
module alu_cmd_issuer
    import alu_cmd_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_func,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    output logic [31:0] cmd,
    input  logic [7:0]  alu_res,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_res,
    output logic [3:0]  rsp_func,
    output logic        rsp_dbz,
`ifdef CMD_TAG_EN
    output logic [7:0]  rsp_tag,
`endif
    output logic        busy
);

    localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    issuer_state_t r_state;
    issuer_state_t w_state_next;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_cmd;
    logic          r_rsp_valid;
    logic [7:0]    r_rsp_res;
    logic [3:0]    r_rsp_func;
    logic          r_rsp_dbz;
    alu_req_t      w_req;
    alu_req_t      w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_issue;
    logic          w_capture;
    logic          w_release;
    logic          w_dbz;
    logic [31:0]   w_cmd_next;

    assign w_req = '{func: req_func, a: req_a, b: req_b};

    alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (req_valid),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_issue      = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_issue      = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == CW'(1)) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_release    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Divide-by-zero is judged from the issued command word, not from the FIFO head.
    assign w_dbz = (r_cmd[CMD_FUNC_MSB:CMD_FUNC_LSB] == FN_DIV) && (r_cmd[CMD_B_MSB -: 8] == 8'h00);

`ifdef CMD_TAG_EN
    logic [7:0] r_tag;
    logic [7:0] r_rsp_tag;

    assign w_cmd_next = pack_cmd(w_head.func, w_head.a, w_head.b) | {8'h00, r_tag, 16'h0000};
    assign rsp_tag    = r_rsp_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag     <= 8'h00;
            r_rsp_tag <= 8'h00;
        end else begin
            if (w_issue)   r_tag     <= r_tag + 8'd1;
            if (w_capture) r_rsp_tag <= r_cmd[CMD_TAG_MSB -: 8];
        end
    end
`else
    assign w_cmd_next = pack_cmd(w_head.func, w_head.a, w_head.b);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_cmd       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_res   <= 8'h00;
            r_rsp_func  <= 4'h0;
            r_rsp_dbz   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_cmd <= w_cmd_next;
                r_cnt <= CW'(ALU_LAT);
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_capture) begin
                r_rsp_valid <= 1'b1;
                r_rsp_res   <= w_dbz ? 8'hFF : alu_res;
                r_rsp_func  <= r_cmd[CMD_FUNC_MSB:CMD_FUNC_LSB];
                r_rsp_dbz   <= w_dbz;
            end else if (w_release) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready = !w_full;
    assign cmd       = r_cmd;
    assign rsp_valid = r_rsp_valid;
    assign rsp_res   = r_rsp_res;
    assign rsp_func  = r_rsp_func;
    assign rsp_dbz   = r_rsp_dbz;
    assign busy      = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - vector table plus scoreboard for alu_cmd_issuer (ALU_LAT 1 and 3)
module tb_alu_cmd_issuer;
    import alu_cmd_pkg::*;

    typedef struct {
        logic [3:0]  func;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [31:0] cmd;
        logic [7:0]  res;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] cmd;
        logic [7:0]  res;
        logic [3:0]  func;
        logic        dbz;
        logic [7:0]  tag;
    } exp_t;

`ifdef CMD_TAG_EN
    localparam logic [31:0] CMD_MASK = 32'hFF00_FFFF;
`else
    localparam logic [31:0] CMD_MASK = 32'hFFFF_FFFF;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [3:0]  req_func = 4'h0;
    logic [7:0]  req_a = 8'h00, req_b = 8'h00;
    logic [31:0] cmd;
    logic [7:0]  alu_res;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [7:0]  rsp_res;
    logic [3:0]  rsp_func;
    logic        rsp_dbz, busy;
    logic [7:0]  rsp_tag;

    logic        req_valid3 = 1'b0, req_ready3;
    logic [3:0]  req_func3 = 4'h0;
    logic [7:0]  req_a3 = 8'h00, req_b3 = 8'h00;
    logic [31:0] cmd3;
    logic [7:0]  alu_res3;
    logic        rsp_valid3, rsp_ready3 = 1'b0;
    logic [7:0]  rsp_res3;
    logic [3:0]  rsp_func3;
    logic        rsp_dbz3, busy3;
    logic [7:0]  rsp_tag3;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cur_exp;
    exp_t mon_e;
    logic [7:0] tag_cnt = 8'h00;
    vec_t vecs[10];

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = {8'h00, a} * {8'h00, b};
        case (f)
            FN_ADD: return a + b;
            FN_SUB: return a - b;
            FN_MUL: return p[7:0];
            FN_DIV: return (b == 8'h00) ? 8'h00 : a / b;
            FN_AND: return a & b;
            FN_OR:  return a | b;
            FN_XOR: return a ^ b;
            FN_NOT: return ~a;
            FN_PA:  return a;
            FN_PB:  return b;
            FN_SLL: return a << b[2:0];
            FN_SRL: return a >> b[2:0];
            FN_SRA: return 8'($signed(a) >>> b[2:0]);
            FN_INC: return a + 8'd1;
            FN_DEC: return a - 8'd1;
            default: return 8'($countones(a));
        endcase
    endfunction

    assign alu_res  = alu_f(cmd[31:28], cmd[15:8], cmd[7:0]);
    assign alu_res3 = alu_f(cmd3[31:28], cmd3[15:8], cmd3[7:0]);

    alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_func(req_func), .req_a(req_a), .req_b(req_b), .cmd(cmd), .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_func(rsp_func),
        .rsp_dbz(rsp_dbz),
`ifdef CMD_TAG_EN
        .rsp_tag(rsp_tag),
`endif
        .busy(busy)
    );

    alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_func(req_func3), .req_a(req_a3), .req_b(req_b3), .cmd(cmd3), .alu_res(alu_res3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_res(rsp_res3), .rsp_func(rsp_func3),
        .rsp_dbz(rsp_dbz3),
`ifdef CMD_TAG_EN
        .rsp_tag(rsp_tag3),
`endif
        .busy(busy3)
    );

`ifndef CMD_TAG_EN
    assign rsp_tag  = 8'h00;
    assign rsp_tag3 = 8'h00;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: accepted requests enqueue their expectation, response handshakes dequeue.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && req_ready) begin
                mon_e     = cur_exp;
                mon_e.tag = tag_cnt;
                tag_cnt   = tag_cnt + 8'd1;
                sb.push_back(mon_e);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=%h required=none", rsp_res);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_res", {24'h0, rsp_res}, {24'h0, mon_e.res});
                    chk("rsp_func", {28'h0, rsp_func}, {28'h0, mon_e.func});
                    chk("rsp_dbz", {31'h0, rsp_dbz}, {31'h0, mon_e.dbz});
                    chk("rsp_cmd", cmd & CMD_MASK, mon_e.cmd);
`ifdef CMD_TAG_EN
                    chk("cmd_tag", {24'h0, cmd[23:16]}, {24'h0, mon_e.tag});
                    chk("rsp_tag", {24'h0, rsp_tag}, {24'h0, mon_e.tag});
`endif
                end
            end
        end
    end

    task automatic drive(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                         input logic [31:0] ecmd, input logic [7:0] eres, input logic edbz);
        req_func     = f;
        req_a        = a;
        req_b        = b;
        cur_exp.cmd  = ecmd;
        cur_exp.res  = eres;
        cur_exp.func = f;
        cur_exp.dbz  = edbz;
        cur_exp.tag  = 8'h00;
        req_valid    = 1'b1;
    endtask

    task automatic drive_m(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        logic dz;
        dz = (f == FN_DIV) && (b == 8'h00);
        drive(f, a, b, {f, 12'h000, a, b}, dz ? 8'hFF : alu_f(f, a, b), dz);
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_ready required=ready");
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic send_m(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        drive_m(f, a, b);
        wait_accept();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy) && n < 2000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0 || busy) begin
            errors++;
            $display("FAIL %s_drain actual=pending%0d_busy%b required=pending0_busy0", name, sb.size(), busy);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{FN_ADD, 8'h05, 8'h03, 32'h0000_0503, 8'h08, 1'b0};
        vecs[1] = '{FN_DIV, 8'h20, 8'h00, 32'h3000_2000, 8'hFF, 1'b1};
        vecs[2] = '{FN_DIV, 8'h20, 8'h04, 32'h3000_2004, 8'h08, 1'b0};
        vecs[3] = '{FN_SUB, 8'h10, 8'h01, 32'h1000_1001, 8'h0F, 1'b0};
        vecs[4] = '{FN_XOR, 8'hF0, 8'hFF, 32'h6000_F0FF, 8'h0F, 1'b0};
        vecs[5] = '{FN_HAM, 8'hA5, 8'h00, 32'hF000_A500, 8'h04, 1'b0};
        vecs[6] = '{FN_SRA, 8'h80, 8'h02, 32'hC000_8002, 8'hE0, 1'b0};
        vecs[7] = '{FN_INC, 8'hFF, 8'h00, 32'hD000_FF00, 8'h00, 1'b0};
        vecs[8] = '{FN_MUL, 8'h10, 8'h10, 32'h2000_1010, 8'h00, 1'b0};
        vecs[9] = '{FN_AND, 8'hFF, 8'h00, 32'h4000_FF00, 8'h00, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_cmd", cmd, 32'h0);
        chk("rst_rsp_res", {24'h0, rsp_res}, 32'h0);
        chk("rst_rsp_func", {28'h0, rsp_func}, 32'h0);
        chk("rst_rsp_dbz", {31'h0, rsp_dbz}, 32'h0);
        @(posedge clk);
        #1;

        // ALU_LAT=3: INC of 8'hFF; cmd held three cycles, busy until the handshake.
        req_func3 = FN_INC; req_a3 = 8'hFF; req_b3 = 8'h00; req_valid3 = 1'b1;
        @(posedge clk); #1 req_valid3 = 1'b0;
        chk("lat3_busy_queued", {31'h0, busy3}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("lat3_cmd_stable", cmd3, 32'hD000_FF00 & CMD_MASK | (cmd3 & ~CMD_MASK));
            chk("lat3_no_rsp_yet", {31'h0, rsp_valid3}, 32'h0);
        end
        @(posedge clk); #1;
        chk("lat3_rsp_valid", {31'h0, rsp_valid3}, 32'h1);
        chk("lat3_rsp_res", {24'h0, rsp_res3}, 32'h0);
        chk("lat3_rsp_func", {28'h0, rsp_func3}, {28'h0, FN_INC});
        @(posedge clk); #1;
        chk("lat3_busy_held", {31'h0, busy3}, 32'h1);
        chk("lat3_rsp_held", {31'h0, rsp_valid3}, 32'h1);
        rsp_ready3 = 1'b1;
        @(posedge clk); #1;
        chk("lat3_rsp_cleared", {31'h0, rsp_valid3}, 32'h0);
        chk("lat3_busy_cleared", {31'h0, busy3}, 32'h0);
        rsp_ready3 = 1'b0;

        // ADD latency: rsp_valid two cycles after the accepting edge.
        drive(vecs[0].func, vecs[0].a, vecs[0].b, vecs[0].cmd, vecs[0].res, vecs[0].dbz);
        wait_accept();
        @(posedge clk); #1;
        chk("add_cmd", cmd & CMD_MASK, 32'h0000_0503);
        chk("add_rsp_not_yet", {31'h0, rsp_valid}, 32'h0);
        @(posedge clk); #1;
        chk("add_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        wait_idle("add");

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].cmd, vecs[i].res, vecs[i].dbz);
            wait_accept();
        end
        wait_idle("table");

        // Backpressure: one in flight plus four buffered, sixth held off until space frees.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_m(FN_ADD, 8'(i), 8'h10);
        @(negedge clk);
        chk("bp_full_after_5", {31'h0, req_ready}, 32'h0);
        drive_m(FN_ADD, 8'h05, 8'h10);
        repeat (3) @(negedge clk);
        chk("bp_still_full", {31'h0, req_ready}, 32'h0);
        chk("bp_accepted_count", sb.size(), 32'd5);
        chk("bp_first_rsp_held", {31'h0, rsp_valid}, 32'h1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_accept();
        wait_idle("backpressure");

        // Reset while the second request is in WAIT with two more queued.
        send_m(FN_OR, 8'h0F, 8'hF0);
        send_m(FN_SUB, 8'h09, 8'h02);
        send_m(FN_NOT, 8'h3C, 8'h00);
        send_m(FN_DEC, 8'h00, 8'h00);
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        tag_cnt = 8'h00;
        @(negedge clk);
        chk("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_cmd", cmd, 32'h0);
        chk("mid_rst_req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_idle_busy", {31'h0, busy}, 32'h0);
        chk("post_rst_no_rsp", {31'h0, rsp_valid}, 32'h0);

        send_m(FN_SLL, 8'h03, 8'h02);
        wait_idle("post_reset");

`ifdef CMD_TAG_EN
        for (int i = 0; i < 257; i++) send_m(FN_PA, 8'(i), 8'(i * 3));
        wait_idle("tag_wrap");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
